// File: rtl/uart_rx_if.sv
// Byte handshake between the UART receiver (master) and its consumer (slave).
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop line synchroniser, mid-bit sampling FSM,
// valid/ready byte output with framing-error pulse and sticky overrun flag.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic      s_clk,
  input  logic      rst,
  input  logic      rx_line,
  uart_rx_if.master rxif,
  output logic      busy_flag,
  output logic      frame_err,
  output logic      overrun
);

  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic [1:0]    sync_q;
  logic          rs;

  assign rs = sync_q[1];

  always_ff @(posedge s_clk) begin
    if (rst) begin
      sync_q    <= '1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx_line};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = ovr_q;

    if (valid_q && rxif.rx_ready) valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rs) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rs ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          shift_d   = {rs, shift_q[7:1]};
          cnt_d     = '0;
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == 4'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          // A byte completing on the same cycle the old one is accepted replaces it.
          if (!rs) begin
            ferr_d = 1'b1;
          end else if (!valid_q || rxif.rx_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rxif.rx_data  = data_q;
  assign rxif.rx_valid = valid_q;
  assign busy_flag     = (state_q != IDLE);
  assign frame_err     = ferr_q;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: clean frames, back-to-back, glitch, framing
// error, overrun and mid-frame reset.
module tb_uart_rx;
  localparam int unsigned CPB  = 10;
  localparam int unsigned HALF = CPB / 2;

  logic s_clk = 1'b0;
  logic rst = 1'b1;
  logic rx_line = 1'b1;
  logic busy_flag, frame_err, overrun;

  uart_rx_if rxif ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .s_clk    (s_clk),
    .rst      (rst),
    .rx_line  (rx_line),
    .rxif     (rxif),
    .busy_flag(busy_flag),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 s_clk = ~s_clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] acc[$];
  int ferr_cnt = 0;
  int valid_cyc = 0;
  int first_v = -1;
  int low_run = 0;
  int last_gap = 0;

  always @(posedge s_clk) cyc <= cyc + 1;

  always @(negedge s_clk) begin
    if (!rst) begin
      if (rxif.rx_valid && rxif.rx_ready) acc.push_back(rxif.rx_data);
      if (frame_err) ferr_cnt++;
      if (rxif.rx_valid) begin
        valid_cyc++;
        if (first_v < 0) first_v = cyc;
      end
      if (!busy_flag) low_run++;
      else begin
        if (low_run > 0) last_gap = low_run;
        low_run = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_bit();
    repeat (CPB) @(posedge s_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx_line = 1'b0;
    wait_bit();
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      wait_bit();
    end
    rx_line = stop;
    wait_bit();
    rx_line = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge s_clk);
    #1;
  endtask

  task automatic clear_stats();
    ferr_cnt  = 0;
    valid_cyc = 0;
    first_v   = -1;
  endtask

  initial begin
    int base;
    int start_cyc;
    int lat;

    rxif.rx_ready = 1'b1;
    idle(3);
    check("rst_data", {24'd0, rxif.rx_data}, 32'h00);
    check("rst_valid", {31'd0, rxif.rx_valid}, 0);
    check("rst_busy", {31'd0, busy_flag}, 0);
    check("rst_ferr", {31'd0, frame_err}, 0);
    check("rst_ovr", {31'd0, overrun}, 0);
    rst = 1'b0;
    idle(5);

    // Single clean byte with latency measurement
    clear_stats();
    base = acc.size();
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1);
    idle(5);
    lat = first_v - start_cyc;
    check("a5_count", acc.size() - base, 1);
    if (acc.size() > base) check("a5_data", {24'd0, acc[base]}, 32'hA5);
    check("a5_latency_ok", (lat >= 2 + HALF + 9*CPB - 1 && lat <= 2 + HALF + 9*CPB + 1) ? 1 : 0, 1);
    check("a5_valid_cycles", valid_cyc, 1);
    check("a5_ferr", ferr_cnt, 0);
    check("a5_ovr", {31'd0, overrun}, 0);
    idle(10);

    // Back-to-back frames, no idle gap
    clear_stats();
    base = acc.size();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(5);
    check("b2b_count", acc.size() - base, 2);
    if (acc.size() >= base + 2) begin
      check("b2b_first", {24'd0, acc[base]}, 32'h00);
      check("b2b_second", {24'd0, acc[base+1]}, 32'hFF);
    end
    // Two-flop sync plus mid-stop exit leaves a short idle window before the next start is seen
    check("b2b_gap_ok", (last_gap >= 1 && last_gap <= int'(CPB - HALF) + 1) ? 1 : 0, 1);
    idle(10);

    // Short low glitch on an idle line
    clear_stats();
    base = acc.size();
    rx_line = 1'b0;
    idle(3);
    rx_line = 1'b1;
    idle(2);
    check("glitch_busy_seen", {31'd0, busy_flag}, 1);
    idle(8);
    check("glitch_busy_end", {31'd0, busy_flag}, 0);
    check("glitch_no_valid", valid_cyc, 0);
    check("glitch_no_byte", acc.size() - base, 0);
    idle(10);

    // Framing error then a good frame
    clear_stats();
    base = acc.size();
    send_frame(8'h3C, 1'b0);
    idle(30);
    check("ferr_pulse_len", ferr_cnt, 1);
    check("ferr_no_valid", valid_cyc, 0);
    send_frame(8'h11, 1'b1);
    idle(5);
    check("ferr_next_count", acc.size() - base, 1);
    if (acc.size() > base) check("ferr_next_data", {24'd0, acc[base]}, 32'h11);
    check("ferr_no_extra", ferr_cnt, 1);
    idle(10);

    // Overrun with consumer stalled
    clear_stats();
    base = acc.size();
    rxif.rx_ready = 1'b0;
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    idle(5);
    check("ovr_valid_held", {31'd0, rxif.rx_valid}, 1);
    check("ovr_data_kept", {24'd0, rxif.rx_data}, 32'h12);
    check("ovr_flag", {31'd0, overrun}, 1);
    rxif.rx_ready = 1'b1;
    idle(3);
    check("ovr_accept_count", acc.size() - base, 1);
    if (acc.size() > base) check("ovr_accept_data", {24'd0, acc[base]}, 32'h12);
    check("ovr_valid_clear", {31'd0, rxif.rx_valid}, 0);
    check("ovr_sticky", {31'd0, overrun}, 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("ovr_cleared_by_rst", {31'd0, overrun}, 0);
    idle(10);

    // Reset in the middle of a frame, then a clean frame
    clear_stats();
    base = acc.size();
    rx_line = 1'b0;
    wait_bit();
    for (int i = 0; i < 4; i++) begin
      rx_line = 8'h55 >> i;
      wait_bit();
    end
    check("mid_busy_before_rst", {31'd0, busy_flag}, 1);
    rst = 1'b1;
    rx_line = 1'b1;
    idle(1);
    check("mid_rst_busy", {31'd0, busy_flag}, 0);
    check("mid_rst_valid", {31'd0, rxif.rx_valid}, 0);
    check("mid_rst_data", {24'd0, rxif.rx_data}, 32'h00);
    rst = 1'b0;
    idle(20);
    check("mid_idle_after", {31'd0, busy_flag}, 0);
    send_frame(8'h66, 1'b1);
    idle(5);
    check("mid_count", acc.size() - base, 1);
    if (acc.size() > base) check("mid_data", {24'd0, acc[base]}, 32'h66);
    check("mid_ferr", ferr_cnt, 0);
    check("mid_ovr", {31'd0, overrun}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
